// File: rtl/mips_cpu_avalon_ram_responder.sv
// mips_cpu_avalon_ram_responder: Avalon-MM word RAM with programmable waitrequest stall, byte-lane masking and sticky error flag
module mips_cpu_avalon_ram_responder #(
  parameter logic [31:0] ADDR_BASE     = 32'hBFC0_0000,
  parameter int          DEPTH_WORDS   = 1024,
  parameter int          WAIT_CYCLES   = 1,
  parameter string       RAM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, STALL, DONE} state_t;
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   readdata_q, readdata_d;
  logic          err_q, err_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] widx_q, widx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [29:0]   idx;
  logic          req, legal, enter_done;
  assign req         = read | write;
  assign idx         = 30'((address - ADDR_BASE) >> 2);
  assign legal       = address[1:0] == 2'b00 && {2'b00, idx} < 32'(DEPTH_WORDS);
  assign enter_done  = req && ((state_q == IDLE && WAIT_CYCLES == 0) || (state_q == STALL && cnt_q == 4'd0));
  assign waitrequest = reset | (state_q == IDLE ? req : state_q == STALL);
  assign readdata    = readdata_q;
  assign err         = err_q;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    readdata_d = readdata_q;
    err_d      = err_q;
    wr_d       = wr_q;
    widx_d     = widx_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = WAIT_CYCLES == 0 ? DONE : STALL;
        cnt_d   = WAIT_CYCLES == 0 ? cnt_q : 4'(WAIT_CYCLES - 1);
      end
      STALL: begin
        state_d = !req ? IDLE : cnt_q == 4'd0 ? DONE : STALL;
        cnt_d   = req && cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q;
      end
      default: begin
        state_d = IDLE;
        wr_d    = 1'b0;
      end
    endcase
    if (enter_done) begin
      wr_d       = write && legal;
      widx_d     = idx[AW-1:0];
      wdata_d    = writedata;
      be_d       = byteenable;
      readdata_d = read && !write ? (legal ? mem[idx[AW-1:0]] : 32'h0) : readdata_q;
      err_d      = err_q | !legal | (read & write);
    end
  end
  always_ff @(posedge clk) begin
    widx_q  <= widx_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      readdata_q <= 32'h0;
      err_q      <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      readdata_q <= readdata_d;
      err_q      <= err_d;
      wr_q       <= wr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && state_q == DONE && wr_q)
      for (int i = 0; i < 4; i++)
        if (be_q[i]) mem[widx_q][8*i +: 8] <= wdata_q[8*i +: 8];
  end
endmodule

// File: tb/tb_mips_cpu_avalon_ram_responder.sv
// tb_mips_cpu_avalon_ram_responder: three responders (WAIT_CYCLES 1, 3, 0) driven with directed
// and random transfers, checked against a word-array memory model.
module tb_mips_cpu_avalon_ram_responder;
    localparam logic [31:0] BASE = 32'hBFC0_0000;
    localparam int          WC[3] = '{1, 3, 0};

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ad_i [3];
    logic        rd_i [3];
    logic        wr_i [3];
    logic [31:0] wd_i [3];
    logic [3:0]  be_i [3];
    logic        wait_o [3];
    logic [31:0] rd_o [3];
    logic        err_o [3];

    logic [31:0] ref_m [3][1024];
    logic [31:0] rd_m [3];
    logic        err_m [3];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mips_cpu_avalon_ram_responder #(.WAIT_CYCLES(WC[g])) u_dut (
            .clk(clk), .reset(reset), .address(ad_i[g]), .read(rd_i[g]), .write(wr_i[g]),
            .writedata(wd_i[g]), .byteenable(be_i[g]), .waitrequest(wait_o[g]),
            .readdata(rd_o[g]), .err(err_o[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit legal_addr(input logic [31:0] a);
        return a[1:0] == 2'b00 && (a - BASE) < 32'd4096;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after completion
    task automatic xfer(input int k, input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, input bit hold,
                        output logic [31:0] q, output int n);
        wr_i[k] = w; rd_i[k] = r; ad_i[k] = a; wd_i[k] = d; be_i[k] = b;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (!wait_o[k]) break;
            n++;
            @(posedge clk); #1;
        end
        q = rd_o[k];
        @(posedge clk); #1;
        if (!hold) begin wr_i[k] = 1'b0; rd_i[k] = 1'b0; end
    endtask

    task automatic op(input int k, input logic w, input logic r, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b, input bit hold);
        logic [31:0] q, m;
        int n, i;
        xfer(k, w, r, a, d, b, hold, q, n);
        check("stall", 32'(n), 32'(WC[k] + 1));
        i = int'((a - BASE) >> 2);
        m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        if (!legal_addr(a) || (w && r)) err_m[k] = 1'b1;
        if (w) begin
            if (legal_addr(a)) ref_m[k][i] = (ref_m[k][i] & ~m) | (d & m);
        end else if (r) rd_m[k] = legal_addr(a) ? ref_m[k][i] : 32'h0;
        check("rdata", q, rd_m[k]);
        check("err", 32'(err_o[k]), 32'(err_m[k]));
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin rd_m[k] = 32'h0; err_m[k] = 1'b0; end
    endtask

    initial begin
        logic [31:0] a;
        int sel, kind;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ad_i[k] = BASE; rd_i[k] = 1'b0; wr_i[k] = 1'b0; wd_i[k] = 32'h0; be_i[k] = 4'h0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) check("wait_in_reset", 32'(wait_o[k]), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_rdata", rd_o[k], 32'h0);
            check("rst_err", 32'(err_o[k]), 32'd0);
            check("rst_idle_wait", 32'(wait_o[k]), 32'd0);
        end
        @(posedge clk); #1;

        op(0, 1, 0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
        op(0, 0, 1, BASE + 32'h10, 32'h0, 4'h0, 0);
        op(0, 1, 0, BASE + 32'h20, 32'h1122_3344, 4'hF, 0);
        op(0, 1, 0, BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, 0);
        op(0, 0, 1, BASE + 32'h20, 32'h0, 4'h0, 0);
        op(0, 1, 0, BASE + 32'h20, 32'hFFFF_FFFF, 4'h0, 0);
        op(0, 0, 1, BASE + 32'h20, 32'h0, 4'hF, 0);
        op(1, 1, 0, BASE + 32'h30, 32'hCAFE_F00D, 4'hF, 0);
        op(1, 0, 1, BASE + 32'h30, 32'h0, 4'h0, 0);
        op(2, 1, 0, BASE + 32'h30, 32'h0123_4567, 4'hF, 0);
        op(2, 0, 1, BASE + 32'h30, 32'h0, 4'h0, 0);

        op(0, 1, 0, BASE, 32'h1234_5678, 4'hF, 0);
        op(0, 0, 1, BASE + 32'h10, 32'h0, 4'h0, 1);
        op(0, 0, 1, BASE + 32'h20, 32'h0, 4'h0, 0);

        op(0, 0, 1, BASE + 32'h2, 32'h0, 4'h0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", 32'(err_o[0]), 32'd1);
        op(0, 1, 0, BASE + 32'h1000, 32'hFFFF_FFFF, 4'hF, 0);
        op(0, 0, 1, BASE, 32'h0, 4'h0, 0);

        // Reset during STALL of a held write; the write restarts after release
        op(1, 0, 1, BASE + 32'h30, 32'h0, 4'h0, 0);
        op(1, 1, 0, BASE + 32'h44, 32'h0BAD_F00D, 4'hF, 0);
        wr_i[1] = 1'b1; ad_i[1] = BASE + 32'h40; wd_i[1] = 32'h5555_5555; be_i[1] = 4'hF;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        op(1, 1, 0, BASE + 32'h40, 32'h5555_5555, 4'hF, 0);
        for (int k = 0; k < 3; k++) check("rst_err_all", 32'(err_o[k]), 32'd0);
        op(1, 0, 1, BASE + 32'h40, 32'h0, 4'h0, 0);

        // Reset during STALL with the write withdrawn: word must survive
        wr_i[1] = 1'b1; ad_i[1] = BASE + 32'h44; wd_i[1] = 32'h5555_5555; be_i[1] = 4'hF;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1; wr_i[1] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        op(1, 0, 1, BASE + 32'h44, 32'h0, 4'h0, 0);

        // Reset in the DONE cycle of a zero-wait write: no commit
        wr_i[2] = 1'b1; ad_i[2] = BASE + 32'h30; wd_i[2] = 32'h5555_5555; be_i[2] = 4'hF;
        @(posedge clk); #1;
        reset = 1'b1; wr_i[2] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        op(2, 0, 1, BASE + 32'h30, 32'h0, 4'h0, 0);

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) op(k, 1, 0, BASE + 32'(4 * i), $urandom, 4'hF, 0);
            for (int t = 0; t < 40; t++) begin
                kind = int'($urandom_range(0, 9));
                a = BASE + 32'(4 * $urandom_range(0, 15));
                if (kind == 0) a = a | 32'($urandom_range(1, 3));
                else if (kind == 1) a = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 255));
                else if (kind == 2) a = BASE - 32'(4 * $urandom_range(1, 64));
                sel = int'($urandom_range(0, 7));
                op(k, sel <= 3, sel >= 3, a, $urandom, 4'($urandom_range(0, 15)),
                   t != 39 && $urandom_range(0, 3) == 0);
            end
            wr_i[k] = 1'b0; rd_i[k] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
